seg_execute_md: RTL and testbench

Parametrised execute stage for the pipelined MIPS core, successor to the single-cycle combinational execute stage. Adds a registered EX/MEM output boundary, an iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) with architectural HI/LO registers, MFHI/MFLO readout, and a stall handshake toward decode. It sits between the ID/EX register and the memory stage.

---
 rtl/seg_execute_md.sv | 226 ++++++++++++++++++++++
 tb/tb_seg_execute_md.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_execute_md.sv
// seg_execute_md: pipelined execute stage with a registered EX/MEM boundary,
// an iterative multiply/divide unit (one bit per cycle) and HI/LO registers.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid                 instruction present from ID/EX
//   i_pc                    PC+4 of the instruction
//   i_read_data_1/2         rs / rt operands
//   i_imm_ext               sign-extended immediate
//   i_rt, i_rd              candidate destination registers
//   i_alu_ctl, i_alu_src    ALU op and B-operand select
//   i_reg_dst               1: dest = i_rd, 0: dest = i_rt
//   i_md_op                 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO
//   i_ctrl_wb_bus/mem_bus   downstream control
//   o_stall                 combinational: instruction not accepted this cycle
//   o_valid .. o_ctrl_*     registered EX/MEM outputs
//   o_md_busy               mul/div iteration in progress
module seg_execute_md #(
  parameter int LEN        = 32,
  parameter int NB_ADDR    = 5,
  parameter int NB_ALUCTL  = 4,
  parameter int NB_MDOP    = 3,
  parameter int NB_CTRL_WB = 2,
  parameter int NB_CTRL_M  = 3,
  parameter int NB_CNT     = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [LEN-1:0]        i_pc,
  input  logic [LEN-1:0]        i_read_data_1,
  input  logic [LEN-1:0]        i_read_data_2,
  input  logic [LEN-1:0]        i_imm_ext,
  input  logic [NB_ADDR-1:0]    i_rt,
  input  logic [NB_ADDR-1:0]    i_rd,
  input  logic [NB_ALUCTL-1:0]  i_alu_ctl,
  input  logic                  i_alu_src,
  input  logic                  i_reg_dst,
  input  logic [NB_MDOP-1:0]    i_md_op,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [LEN-1:0]        o_pc_branch,
  output logic [LEN-1:0]        o_alu_result,
  output logic                  o_zero,
  output logic [LEN-1:0]        o_write_data,
  output logic [NB_ADDR-1:0]    o_write_register,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem_bus,
  output logic                  o_md_busy
);

  typedef enum logic [NB_ALUCTL-1:0] {
    ALU_AND = NB_ALUCTL'(0),
    ALU_OR  = NB_ALUCTL'(1),
    ALU_ADD = NB_ALUCTL'(2),
    ALU_SUB = NB_ALUCTL'(6),
    ALU_SLT = NB_ALUCTL'(7),
    ALU_NOR = NB_ALUCTL'(12)
  } alu_e;

  typedef enum logic [NB_MDOP-1:0] {
    MD_NONE  = NB_MDOP'(0),
    MD_MULT  = NB_MDOP'(1),
    MD_MULTU = NB_MDOP'(2),
    MD_DIV   = NB_MDOP'(3),
    MD_DIVU  = NB_MDOP'(4),
    MD_MFHI  = NB_MDOP'(5),
    MD_MFLO  = NB_MDOP'(6),
    MD_RSVD  = NB_MDOP'(7)
  } md_e;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e              r_state;
  logic [NB_CNT-1:0]   r_cnt;
  logic                r_is_div;
  logic                r_neg_p;   // negate product / quotient
  logic                r_neg_r;   // negate remainder
  logic                r_div0;
  logic [LEN-1:0]      r_a;
  logic [LEN-1:0]      r_opnd;    // |multiplicand| or |divisor|
  logic [2*LEN-1:0]    r_acc;     // {partial hi / remainder, multiplier / quotient}
  logic [LEN-1:0]      r_hi;
  logic [LEN-1:0]      r_lo;

  logic                w_md_start, w_md_any, w_accept, w_signed, w_is_div;
  logic                w_neg_a, w_neg_b;
  logic [LEN-1:0]      w_mag_a, w_mag_b, w_b, w_alu, w_result;
  logic [LEN:0]        w_mul_sum, w_div_shift, w_div_diff;
  logic [2*LEN-1:0]    w_mul_next, w_div_next, w_mul_fix;
  logic [LEN-1:0]      w_quo, w_rem, w_hi_fin, w_lo_fin;

  assign o_md_busy  = (r_state == ST_BUSY);
  assign w_md_start = (i_md_op == MD_MULT) || (i_md_op == MD_MULTU) ||
                      (i_md_op == MD_DIV)  || (i_md_op == MD_DIVU);
  assign w_md_any   = w_md_start || (i_md_op == MD_MFHI) || (i_md_op == MD_MFLO);
  assign o_stall    = i_valid & o_md_busy & w_md_any;
  assign w_accept   = i_valid & ~o_stall;

  assign w_is_div = (i_md_op == MD_DIV) || (i_md_op == MD_DIVU);
  assign w_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
  assign w_neg_a  = w_signed & i_read_data_1[LEN-1];
  assign w_neg_b  = w_signed & i_read_data_2[LEN-1];
  assign w_mag_a  = w_neg_a ? -i_read_data_1 : i_read_data_1;
  assign w_mag_b  = w_neg_b ? -i_read_data_2 : i_read_data_2;

  assign w_b = i_alu_src ? i_imm_ext : i_read_data_2;

  always_comb begin
    w_alu = '0;
    case (i_alu_ctl)
      ALU_AND: w_alu = i_read_data_1 & w_b;
      ALU_OR:  w_alu = i_read_data_1 | w_b;
      ALU_ADD: w_alu = i_read_data_1 + w_b;
      ALU_SUB: w_alu = i_read_data_1 - w_b;
      ALU_SLT: w_alu = {{(LEN-1){1'b0}}, ($signed(i_read_data_1) < $signed(w_b))};
      ALU_NOR: w_alu = ~(i_read_data_1 | w_b);
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_result = w_alu;
    if (i_md_op == MD_MFHI) w_result = r_hi;
    else if (i_md_op == MD_MFLO) w_result = r_lo;
  end

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*LEN-1:LEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[LEN-1:1]};

  // Restoring step: shift remainder:dividend left, trial-subtract the divisor,
  // keep the difference and shift in a 1 when it does not go negative.
  assign w_div_shift = r_acc[2*LEN-1:LEN-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_div_next  = w_div_diff[LEN] ? {w_div_shift[LEN-1:0], r_acc[LEN-2:0], 1'b0}
                                       : {w_div_diff[LEN-1:0],  r_acc[LEN-2:0], 1'b1};

  // Sign fix-up applied to the last iteration's result so completion costs no extra cycle.
  assign w_mul_fix = r_neg_p ? -w_mul_next : w_mul_next;
  assign w_quo     = w_div_next[LEN-1:0];
  assign w_rem     = w_div_next[2*LEN-1:LEN];

  always_comb begin
    w_hi_fin = w_mul_fix[2*LEN-1:LEN];
    w_lo_fin = w_mul_fix[LEN-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_hi_fin = r_a;
        w_lo_fin = '1;
      end else begin
        w_hi_fin = r_neg_r ? -w_rem : w_rem;
        w_lo_fin = r_neg_p ? -w_quo : w_quo;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_is_div         <= 1'b0;
      r_neg_p          <= 1'b0;
      r_neg_r          <= 1'b0;
      r_div0           <= 1'b0;
      r_a              <= '0;
      r_opnd           <= '0;
      r_acc            <= '0;
      r_hi             <= '0;
      r_lo             <= '0;
      o_valid          <= 1'b0;
      o_pc_branch      <= '0;
      o_alu_result     <= '0;
      o_zero           <= 1'b0;
      o_write_data     <= '0;
      o_write_register <= '0;
      o_ctrl_wb_bus    <= '0;
      o_ctrl_mem_bus   <= '0;
    end else begin
      o_valid <= w_accept;
      if (w_accept) begin
        o_pc_branch      <= i_pc + (i_imm_ext << 2);
        o_alu_result     <= w_result;
        o_zero           <= (w_result == '0);
        o_write_data     <= i_read_data_2;
        o_write_register <= i_reg_dst ? i_rd : i_rt;
        o_ctrl_wb_bus    <= w_md_start ? '0 : i_ctrl_wb_bus;
        o_ctrl_mem_bus   <= w_md_start ? '0 : i_ctrl_mem_bus;
      end else begin
        o_ctrl_wb_bus    <= '0;
        o_ctrl_mem_bus   <= '0;
      end

      case (r_state)
        ST_BUSY: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == NB_CNT'(1)) begin
            r_hi    <= w_hi_fin;
            r_lo    <= w_lo_fin;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - NB_CNT'(1);
          end
        end
        default: begin
          if (w_accept && w_md_start) begin
            r_state  <= ST_BUSY;
            r_cnt    <= NB_CNT'(LEN);
            r_is_div <= w_is_div;
            r_neg_p  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_div0   <= (i_read_data_2 == '0);
            r_a      <= i_read_data_1;
            r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
            r_acc    <= {{LEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_execute_md.sv
module tb_seg_execute_md;
  localparam int LEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_pc, i_rd1, i_rd2, i_imm;
  logic [4:0]  i_rt, i_rd;
  logic [3:0]  i_alu_ctl;
  logic        i_alu_src, i_reg_dst;
  logic [2:0]  i_md_op;
  logic [1:0]  i_wb;
  logic [2:0]  i_mem;
  logic        o_stall, o_valid, o_zero, o_md_busy;
  logic [31:0] o_pc_branch, o_alu_result, o_write_data;
  logic [4:0]  o_write_register;
  logic [1:0]  o_wb;
  logic [2:0]  o_mem;

  seg_execute_md #(.LEN(32), .NB_ADDR(5), .NB_ALUCTL(4), .NB_MDOP(3),
                   .NB_CTRL_WB(2), .NB_CTRL_M(3), .NB_CNT(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_pc(i_pc),
    .i_read_data_1(i_rd1), .i_read_data_2(i_rd2), .i_imm_ext(i_imm),
    .i_rt(i_rt), .i_rd(i_rd), .i_alu_ctl(i_alu_ctl), .i_alu_src(i_alu_src),
    .i_reg_dst(i_reg_dst), .i_md_op(i_md_op), .i_ctrl_wb_bus(i_wb),
    .i_ctrl_mem_bus(i_mem), .o_stall(o_stall), .o_valid(o_valid),
    .o_pc_branch(o_pc_branch), .o_alu_result(o_alu_result), .o_zero(o_zero),
    .o_write_data(o_write_data), .o_write_register(o_write_register),
    .o_ctrl_wb_bus(o_wb), .o_ctrl_mem_bus(o_mem), .o_md_busy(o_md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        chk_data;
    logic [31:0] pcb;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [1:0]  wb;
    logic [2:0]  mem;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops one expectation per valid EX/MEM output; bubbles must carry no control.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_valid) begin
        if (q.size() == 0) chk("queue_nonempty", q.size(), 1);
        else begin
          e = q.pop_front();
          chk({e.name, "_latency"}, cyc, e.cyc + 1);
          chk({e.name, "_wb"}, o_wb, e.wb);
          chk({e.name, "_mem"}, o_mem, e.mem);
          chk({e.name, "_wreg"}, o_write_register, e.wr);
          chk({e.name, "_pcb"}, o_pc_branch, e.pcb);
          chk({e.name, "_wdata"}, o_write_data, e.wd);
          if (e.chk_data) begin
            chk({e.name, "_result"}, o_alu_result, e.res);
            chk({e.name, "_zero"}, o_zero, (e.res == 32'h0));
          end
        end
      end else begin
        chk("bubble_wb", o_wb, 0);
        chk("bubble_mem", o_mem, 0);
      end
    end
  end

  task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [3:0] ctl, input logic src,
                      input logic [2:0] md, input logic dst, input logic [31:0] exp_res,
                      input logic cd, output int stalls);
    exp_t e;
    i_valid = 1'b1; i_rd1 = a; i_rd2 = b; i_imm = imm; i_alu_ctl = ctl;
    i_alu_src = src; i_md_op = md; i_reg_dst = dst;
    stalls = 0;
    #1;
    while (o_stall && stalls < 200) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (o_stall) chk({name, "_stall_timeout"}, o_stall, 0);
    e.name = name; e.res = exp_res; e.chk_data = cd;
    e.pcb  = i_pc + (imm << 2);
    e.wd   = b;
    e.wr   = dst ? i_rd : i_rt;
    e.wb   = (md >= 3'd1 && md <= 3'd4) ? 2'b00 : i_wb;
    e.mem  = (md >= 3'd1 && md <= 3'd4) ? 3'b000 : i_mem;
    e.cyc  = cyc;
    q.push_back(e);
    @(posedge clk); #1;
    i_valid = 1'b0; i_md_op = 3'd0;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s;
    rst = 1'b1; i_valid = 1'b0; i_pc = 32'h0000_1000; i_rd1 = '0; i_rd2 = '0;
    i_imm = '0; i_rt = 5'd5; i_rd = 5'd9; i_alu_ctl = 4'd0; i_alu_src = 1'b0;
    i_reg_dst = 1'b0; i_md_op = 3'd0; i_wb = 2'b11; i_mem = 3'b101;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_alu_result, 0);
    chk("rst_busy", o_md_busy, 0);
    chk("rst_stall", o_stall, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // ALU: ADD 5+(-7), SUB 9-9 via immediate, then an idle cycle (bubble)
    send("add", 32'd5, 32'hFFFF_FFF9, 32'h10, 4'b0010, 1'b0, 3'd0, 1'b1, 32'hFFFF_FFFE, 1'b1, s);
    chk("add_stalls", s, 0);
    send("sub", 32'd9, 32'h0, 32'd9, 4'b0110, 1'b1, 3'd0, 1'b0, 32'h0, 1'b1, s);
    idle(1);
    chk("idle_valid", o_valid, 0);
    send("nor", 32'h0, 32'h0, 32'h0, 4'b1100, 1'b0, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, s);
    send("and", 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 4'b0000, 1'b0, 3'd0, 1'b1, 32'h00F0_1234, 1'b1, s);

    // MULT -3*7, then MFLO must wait LEN cycles
    send("mult", 32'hFFFF_FFFD, 32'd7, 32'h0, 4'b0010, 1'b0, 3'd1, 1'b1, 32'h0, 1'b0, s);
    chk("mult_busy", o_md_busy, 1);
    send("mflo_mult", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd6, 1'b1, 32'hFFFF_FFEB, 1'b1, s);
    chk("mflo_stalls", s, LEN);
    send("mfhi_mult", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, s);
    chk("mfhi_stalls", s, 0);

    send("multu", 32'hFFFF_FFFD, 32'd7, 32'h0, 4'b0010, 1'b0, 3'd2, 1'b1, 32'h0, 1'b0, s);
    send("mflo_multu", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd6, 1'b1, 32'hFFFF_FFEB, 1'b1, s);
    send("mfhi_multu", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd5, 1'b1, 32'h0000_0006, 1'b1, s);

    // DIV -7/2, DIVU 7/0, DIV MIN/-1
    send("div", 32'hFFFF_FFF9, 32'd2, 32'h0, 4'b0010, 1'b0, 3'd3, 1'b1, 32'h0, 1'b0, s);
    send("mflo_div", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd6, 1'b1, 32'hFFFF_FFFD, 1'b1, s);
    send("mfhi_div", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, s);
    send("divu0", 32'd7, 32'd0, 32'h0, 4'b0010, 1'b0, 3'd4, 1'b1, 32'h0, 1'b0, s);
    send("mflo_divu0", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd6, 1'b1, 32'hFFFF_FFFF, 1'b1, s);
    send("mfhi_divu0", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd5, 1'b1, 32'h0000_0007, 1'b1, s);
    send("divmin", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 4'b0010, 1'b0, 3'd3, 1'b1, 32'h0, 1'b0, s);
    send("mflo_divmin", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd6, 1'b1, 32'h8000_0000, 1'b1, s);
    send("mfhi_divmin", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd5, 1'b1, 32'h0, 1'b1, s);

    // DIV 100/7 in flight while non-md ops stream through unstalled
    send("div100", 32'd100, 32'd7, 32'h0, 4'b0010, 1'b0, 3'd3, 1'b1, 32'h0, 1'b0, s);
    send("or_busy", 32'h0000_00F0, 32'h0000_000F, 32'h0, 4'b0001, 1'b0, 3'd0, 1'b1, 32'h0000_00FF, 1'b1, s);
    chk("or_busy_stalls", s, 0);
    send("slt_busy_t", 32'hFFFF_FFFF, 32'd1, 32'h0, 4'b0111, 1'b0, 3'd0, 1'b1, 32'h1, 1'b1, s);
    chk("slt_t_stalls", s, 0);
    send("slt_busy_f", 32'd1, 32'hFFFF_FFFF, 32'h0, 4'b0111, 1'b0, 3'd0, 1'b1, 32'h0, 1'b1, s);
    send("or_rsvd", 32'h0, 32'h0, 32'h0, 4'b0001, 1'b0, 3'd7, 1'b1, 32'h0, 1'b1, s);
    chk("or_rsvd_stalls", s, 0);
    chk("div100_still_busy", o_md_busy, 1);
    send("mflo_div100", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd6, 1'b1, 32'h0000_000E, 1'b1, s);
    chk("mflo_div100_stalls", s, LEN - 4);
    send("mfhi_div100", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd5, 1'b1, 32'h0000_0002, 1'b1, s);

    // Reset 10 cycles into a MULT aborts it and clears HI/LO
    send("mult_rst", 32'd5, 32'd5, 32'h4, 4'b0010, 1'b0, 3'd1, 1'b1, 32'h0, 1'b0, s);
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", o_md_busy, 1);
    rst = 1'b1;
    #1;
    chk("rst2_busy", o_md_busy, 0);
    chk("rst2_valid", o_valid, 0);
    chk("rst2_result", o_alu_result, 0);
    chk("rst2_pcb", o_pc_branch, 0);
    chk("rst2_wreg", o_write_register, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    send("mflo_rst", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd6, 1'b1, 32'h0, 1'b1, s);
    chk("mflo_rst_stalls", s, 0);
    send("mfhi_rst", 32'h0, 32'h0, 32'h0, 4'b0010, 1'b0, 3'd5, 1'b1, 32'h0, 1'b1, s);

    idle(3);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
